// File: rtl/instr_mem_multiport.sv
// N-read-port instruction memory with a handshaked run-time program-load port.
// Define INSTR_MEM_RANGE_CHECK_EN for out-of-range detection (END_OPCODE + range_fault).
module instr_mem_multiport #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int END_OPCODE = 38
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          rd_en,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  output logic [NUM_CORES*DATA_W-1:0]   instruction,
  output logic [NUM_CORES-1:0]          instr_valid,
`ifdef INSTR_MEM_RANGE_CHECK_EN
  output logic [NUM_CORES-1:0]          range_fault,
`endif
  input  logic                          load_start,
  input  logic [ADDR_W-1:0]             load_base,
  input  logic                          load_valid,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic                          busy,
  output logic                          load_done,
  output logic                          load_overflow,
  output logic [ADDR_W:0]               load_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  base_idx;
  logic              base_oor;
  logic              at_end;
  logic              wr_en;
  logic [IDX_W-1:0]  rd_idx [NUM_CORES];
  logic              rd_oor [NUM_CORES];

  // Address decode: wrap modulo DEPTH unless range checking is compiled in.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
`ifdef INSTR_MEM_RANGE_CHECK_EN
      rd_oor[i] = (32'(addr[i*ADDR_W +: ADDR_W]) >= DEPTH);
      rd_idx[i] = IDX_W'(addr[i*ADDR_W +: ADDR_W]);
`else
      rd_oor[i] = 1'b0;
      rd_idx[i] = IDX_W'(32'(addr[i*ADDR_W +: ADDR_W]) % DEPTH);
`endif
    end
`ifdef INSTR_MEM_RANGE_CHECK_EN
    base_oor = (32'(load_base) >= DEPTH);
    base_idx = IDX_W'(load_base);
`else
    base_oor = 1'b0;
    base_idx = IDX_W'(32'(load_base) % DEPTH);
`endif
  end

  assign at_end = (32'(ptr) == DEPTH - 1);
  assign wr_en  = (state == LOAD) && load_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    load_ready = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = base_oor ? FINISH : LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        if (load_valid && (load_last || at_end)) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Array has no reset so a mid-load reset keeps the words already written.
  always_ff @(posedge clock) begin
    if (wr_en) mem[ptr] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr           <= '0;
      load_count    <= '0;
      load_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            ptr           <= base_idx;
            load_count    <= '0;
            load_overflow <= base_oor;
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr        <= ptr + 1'b1;
            load_count <= load_count + 1'b1;
            if (at_end && !load_last) load_overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= '0;
      instr_valid <= '0;
`ifdef INSTR_MEM_RANGE_CHECK_EN
      range_fault <= '0;
`endif
    end else begin
      instr_valid <= '0;
      if (state == IDLE) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (rd_en[i]) begin
            instr_valid[i] <= 1'b1;
            if (rd_oor[i]) begin
              instruction[i*DATA_W +: DATA_W] <= DATA_W'(END_OPCODE);
`ifdef INSTR_MEM_RANGE_CHECK_EN
              range_fault[i] <= 1'b1;
`endif
            end else begin
              instruction[i*DATA_W +: DATA_W] <= mem[rd_idx[i]];
            end
          end
        end
      end
    end
  end

endmodule
